// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_unit
//  Purpose  : Instruction-fetch front end. Owns the program counter, drives
//             the instruction-memory byte address, captures the memory's
//             registered response one cycle later, and buffers fetched
//             instructions in a small prefetch FIFO that feeds decode at up
//             to one instruction per cycle. Handles decode back-pressure and
//             branch redirects, which squash both the in-flight fetch and all
//             queued wrong-path entries.
//
//  Optional : FETCH_HALT_ON_ZERO_EN
//             When defined, a fetched all-zero word stops fetching and sets
//             HALTED. The zero word is not queued. Entries already queued
//             still drain. A redirect or reset clears HALTED.
//             When undefined, zero words are ordinary instructions and
//             HALTED is tied low.
//
//  Ports    : clk_50     in   1   system clock, rising edge
//             rst        in   1   synchronous active-high reset
//             ADDR       out  32  byte address to instruction memory
//             INST       in   32  memory data for the previous cycle's ADDR
//             BR_TAKEN   in   1   redirect request from execute
//             BR_TARGET  in   32  redirect address (bits [1:0] ignored)
//             STALL      in   1   decode cannot accept this cycle
//             INST_D     out  32  head instruction (NOP_INST when empty)
//             PC_D       out  32  PC of head instruction (0 when empty)
//             VALID_D    out  1   INST_D / PC_D valid
//             HALTED     out  1   fetch halted on a zero word
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_50,
    input  logic        rst,
    output logic [31:0] ADDR,
    input  logic [31:0] INST,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        STALL,
    output logic [31:0] INST_D,
    output logic [31:0] PC_D,
    output logic        VALID_D,
    output logic        HALTED
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_pc_f;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic [31:0]      r_fifo_inst [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_push_wr;     // push that actually writes the FIFO
    logic             w_halt_block;  // suppresses new fetches
    logic             w_issue;
    logic [CNT_W:0]   w_occ;         // occupancy after this cycle's pop, incl. in-flight slot
    logic             w_unused_tgt;

    assign w_unused_tgt = ^BR_TARGET[1:0];

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && !STALL && !BR_TAKEN;
    assign w_push  = r_inflight && !BR_TAKEN;

`ifdef FETCH_HALT_ON_ZERO_EN
    logic r_halted;
    logic w_zero;

    assign w_zero       = (INST == 32'h0000_0000);
    assign w_push_wr    = w_push && !w_zero;
    // The zero word arriving this cycle must already block the fetch that
    // would otherwise be issued alongside it, so ADDR stops on the word after
    // the zero rather than one further.
    assign w_halt_block = r_halted || (w_push && w_zero);
    assign HALTED       = r_halted;
`else
    assign w_push_wr    = w_push;
    assign w_halt_block = 1'b0;
    assign HALTED       = 1'b0;
`endif

    // Credit check: an issue is allowed only if the FIFO still has a slot
    // for its response after counting the entry already in flight and the
    // pop happening this cycle. This keeps pushes from ever landing on a
    // full FIFO.
    assign w_occ   = {1'b0, r_count}
                   + {{CNT_W{1'b0}}, r_inflight}
                   - {{CNT_W{1'b0}}, w_pop};
    assign w_issue = !rst && !BR_TAKEN && !w_halt_block
                   && (w_occ < (CNT_W+1)'(DEPTH));

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ADDR    = r_pc_f;
    assign VALID_D = w_valid;
    assign INST_D  = w_valid ? r_fifo_inst[r_rd_ptr] : NOP_INST;
    assign PC_D    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0000_0000;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: validity is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (w_push_wr) begin
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
            r_fifo_inst[r_wr_ptr] <= INST;
        end
    end

    // ------------------------------------------------------------------
    // PC, in-flight tracking, pointers and count
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_pc_f        <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
`ifdef FETCH_HALT_ON_ZERO_EN
            r_halted      <= 1'b0;
`endif
        end else if (BR_TAKEN) begin
            // Redirect: drop everything on the wrong path, including the
            // response arriving this cycle.
            r_pc_f        <= {BR_TARGET[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
`ifdef FETCH_HALT_ON_ZERO_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            if (w_push_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(w_push_wr) - CNT_W'(w_pop);
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc_f        <= r_pc_f + 32'd4;
                r_inflight_pc <= r_pc_f;
            end
`ifdef FETCH_HALT_ON_ZERO_EN
            if (w_push && w_zero) begin
                r_halted <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue_unit
//  Purpose  : Self-checking bench for fetch_queue_unit. A queue-based model
//             of the fetch front end predicts ADDR / VALID_D / INST_D / PC_D /
//             HALTED every cycle; literal expectations pin the key timings.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk_50;
    logic        rst;
    logic [31:0] ADDR;
    logic [31:0] INST;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        STALL;
    logic [31:0] INST_D;
    logic [31:0] PC_D;
    logic        VALID_D;
    logic        HALTED;

    fetch_queue_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .ADDR      (ADDR),
        .INST      (INST),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .STALL     (STALL),
        .INST_D    (INST_D),
        .PC_D      (PC_D),
        .VALID_D   (VALID_D),
        .HALTED    (HALTED)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Memory contents: unmapped word at 0xA4 reads as zero.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0000_00A4) ? 32'h0000_0000 : (32'h1000_0000 | a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: next fetch address, one optional outstanding
    // fetch, and a queue of {pc, inst} waiting for decode.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic        m_inf;
    logic [31:0] m_inf_pc;
    logic [63:0] m_q[$];
    logic        m_halted;
    bit          m_known = 1'b0;
    logic [31:0] m_last;        // last delivered PC (or redirect target - 4)
    bit          m_have_last = 1'b0;

    task automatic model_step(input logic r, input logic b, input logic [31:0] t, input logic s);
        bit pop, push, zero, issue;
        int occ;
        if (r) begin
            m_pc = RESET_PC; m_inf = 1'b0; m_q.delete(); m_halted = 1'b0;
            m_known = 1'b1;
            m_last = RESET_PC - 32'd4; m_have_last = 1'b1;
            return;
        end
        if (b) begin
            m_pc = {t[31:2], 2'b00}; m_inf = 1'b0; m_q.delete(); m_halted = 1'b0;
            m_last = {t[31:2], 2'b00} - 32'd4; m_have_last = 1'b1;
            return;
        end
        pop   = (m_q.size() != 0) && !s;
        push  = m_inf;
        zero  = HALT_EN && push && (memf(m_inf_pc) == 32'h0);
        occ   = m_q.size() + int'(m_inf) - int'(pop);
        issue = !m_halted && !zero && (occ < DEPTH);
        if (push) chk("PUSH_WHILE_FULL", {31'b0, m_q.size() < DEPTH}, 32'd1);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (zero) m_halted = 1'b1;
            else      m_q.push_back({m_inf_pc, memf(m_inf_pc)});
        end
        m_inf = issue;
        if (issue) begin
            m_inf_pc = m_pc;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance the
    // model, then return the memory response for the address seen at the edge.
    task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic s);
        logic [31:0] a;
        logic [63:0] head;
        rst = r; BR_TAKEN = b; BR_TARGET = t; STALL = s;
        @(negedge clk_50);
        if (m_known) begin
            head = (m_q.size() != 0) ? m_q[0] : {32'h0, NOP_INST};
            chk("ADDR",    ADDR,              m_pc);
            chk("VALID_D", {31'b0, VALID_D},  {31'b0, m_q.size() != 0});
            chk("INST_D",  INST_D,            head[31:0]);
            chk("PC_D",    PC_D,              head[63:32]);
            chk("HALTED",  {31'b0, HALTED},   {31'b0, m_halted});
            // Delivered stream must be gap-free and duplicate-free.
            if (VALID_D && !s && !b && !r && m_have_last) begin
                chk("SEQ", PC_D, m_last + 32'd4);
                m_last = PC_D;
            end
        end
        a = ADDR;
        model_step(r, b, t, s);
        @(posedge clk_50);
        #1;
        INST = memf(a);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        rst = 1'b1; BR_TAKEN = 1'b0; BR_TARGET = 32'h0; STALL = 1'b0; INST = 32'h0;
        @(posedge clk_50);
        #1;

        // 1: reset, then free-running stream
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("RST_VALID", {31'b0, VALID_D}, 32'd0);
        chk("RST_ADDR",  ADDR,   RESET_PC);
        chk("RST_INST",  INST_D, NOP_INST);
        chk("RST_PC",    PC_D,   32'h0);
        chk("RST_HALT",  {31'b0, HALTED}, 32'd0);
        run(1);
        chk("C1_ADDR",  ADDR, 32'h4);
        chk("C1_VALID", {31'b0, VALID_D}, 32'd0);
        run(1);
        chk("C2_VALID", {31'b0, VALID_D}, 32'd1);
        chk("C2_PC",    PC_D,   32'h0);
        chk("C2_INST",  INST_D, 32'h1000_0000);
        run(1);
        chk("C3_PC", PC_D, 32'h4);
        run(3);
        chk("C6_PC",   PC_D, 32'h10);
        chk("C6_ADDR", ADDR, 32'h18);

        // 2: stall six cycles, FIFO fills, ADDR frozen, then resume
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("STALL_ADDR", ADDR, 32'h18);
        chk("STALL_PC",   PC_D, 32'h10);
        run(1);
        chk("REL_PC1", PC_D, 32'h14);
        run(1);
        chk("REL_PC2", PC_D, 32'h18);

        // 3: fill the FIFO, then redirect to an unaligned target
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h43, 1'b0);
        chk("BR_VALID", {31'b0, VALID_D}, 32'd0);
        chk("BR_ADDR",  ADDR, 32'h40);
        run(1);
        chk("BR_VALID2", {31'b0, VALID_D}, 32'd0);
        run(1);
        chk("BR_PC",   PC_D,   32'h40);
        chk("BR_INST", INST_D, 32'h1000_0040);

        // 4: redirect together with stall
        run(2);
        cyc(1'b0, 1'b1, 32'h100, 1'b1);
        chk("BRST_VALID", {31'b0, VALID_D}, 32'd0);
        chk("BRST_ADDR",  ADDR, 32'h100);
        run(2);
        chk("BRST_PC", PC_D, 32'h100);

        // 5: reset pulse mid-stream with a fetch in flight
        run(1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("MRST_VALID", {31'b0, VALID_D}, 32'd0);
        chk("MRST_ADDR",  ADDR, RESET_PC);
        run(1);
        chk("MRST_STALE", {31'b0, VALID_D}, 32'd0);
        run(1);
        chk("MRST_PC", PC_D, 32'h0);

        // 6: stream across the zero word at 0xA4
        cyc(1'b0, 1'b1, 32'h90, 1'b0);
        run(7);
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("HALT_SET",   {31'b0, HALTED},  32'd1);
        chk("HALT_ADDR",  ADDR,             32'hA8);
        chk("HALT_VALID", {31'b0, VALID_D}, 32'd0);
        run(3);
        chk("HALT_HOLD",  {31'b0, HALTED},  32'd1);
        chk("HALT_ADDR2", ADDR,             32'hA8);
`else
        chk("ZERO_PC",   PC_D,   32'hA4);
        chk("ZERO_INST", INST_D, 32'h0);
        chk("ZERO_HALT", {31'b0, HALTED}, 32'd0);
        run(3);
`endif
        cyc(1'b0, 1'b1, 32'h38, 1'b0);
        chk("RES_HALT", {31'b0, HALTED}, 32'd0);
        chk("RES_ADDR", ADDR, 32'h38);
        run(2);
        chk("RES_PC", PC_D, 32'h38);

        // Mixed stall pattern against the model
        pat = 32'hB36C_91E5;
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 32'h0, pat[i]);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
